// File: rtl/neuron_integrator.sv
// Membrane-potential bank for time-multiplexed neurons: saturating event integration
// while idle, and a leak/threshold write-back sweep on each timestep.
module neuron_integrator #(
  parameter int INTEGER_WIDTH   = 8,
  parameter int DATA_WIDTH_FRAC = 0,
  parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int NUM_NEURONS     = 16,
  parameter int ADDR_WIDTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-2:0]        leak,
  input  logic                         evValid,
  output logic                         evReady,
  input  logic [ADDR_WIDTH-1:0]        evAddr,
  input  logic signed [DATA_WIDTH-1:0] evWeight,
  input  logic                         stepStart,
  output logic signed [DATA_WIDTH-1:0] vmemToTh,
  input  logic signed [DATA_WIDTH-1:0] vmemFromTh,
  input  logic                         spikeFromTh,
  output logic                         spikeValid,
  output logic [ADDR_WIDTH-1:0]        spikeAddr,
  output logic                         busy,
  output logic                         stepDone
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_NEURONS - 1);
  localparam logic signed [DATA_WIDTH:0] SAT_MAX = $signed({2'b00, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [DATA_WIDTH:0] SAT_MIN = $signed({2'b11, {(DATA_WIDTH-1){1'b0}}});

  state_e                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0]   bank_q [NUM_NEURONS];
  logic signed [DATA_WIDTH-1:0]   bank_d [NUM_NEURONS];
  logic                           spike_valid_q, spike_valid_d;
  logic [ADDR_WIDTH-1:0]          spike_addr_q, spike_addr_d;
  logic                           step_done_q, step_done_d;

  logic signed [DATA_WIDTH-1:0]   ev_cur, sw_cur, ev_sat, leaked;
  logic signed [DATA_WIDTH:0]     ev_sum, lk_dn, lk_up, leak_ext;

  // Out-of-range addresses match no entry, so such events read zero and write nothing.
  always_comb begin
    ev_cur = '0;
    sw_cur = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (evAddr == ADDR_WIDTH'(n)) ev_cur = bank_q[n];
      if (idx_q == ADDR_WIDTH'(n))  sw_cur = bank_q[n];
    end
  end

  always_comb begin
    ev_sum = {ev_cur[DATA_WIDTH-1], ev_cur} + {evWeight[DATA_WIDTH-1], evWeight};
    if (ev_sum > SAT_MAX)      ev_sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (ev_sum < SAT_MIN) ev_sat = SAT_MIN[DATA_WIDTH-1:0];
    else                       ev_sat = ev_sum[DATA_WIDTH-1:0];
  end

  // Leak moves toward zero and clamps there rather than crossing sign.
  always_comb begin
    leak_ext = {2'b00, leak};
    lk_dn    = {sw_cur[DATA_WIDTH-1], sw_cur} - leak_ext;
    lk_up    = {sw_cur[DATA_WIDTH-1], sw_cur} + leak_ext;
    if (sw_cur > 0)      leaked = (lk_dn < 0) ? '0 : lk_dn[DATA_WIDTH-1:0];
    else if (sw_cur < 0) leaked = (lk_up > 0) ? '0 : lk_up[DATA_WIDTH-1:0];
    else                 leaked = '0;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    bank_d        = bank_q;
    spike_valid_d = 1'b0;
    spike_addr_d  = spike_addr_q;
    step_done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (evValid) begin
        for (int n = 0; n < NUM_NEURONS; n++)
          if (evAddr == ADDR_WIDTH'(n)) bank_d[n] = ev_sat;
      end
      if (stepStart) begin
        state_d = SWEEP;
        idx_d   = '0;
      end
    end else begin
      for (int n = 0; n < NUM_NEURONS; n++)
        if (idx_q == ADDR_WIDTH'(n)) bank_d[n] = vmemFromTh;
      spike_valid_d = spikeFromTh;
      spike_addr_d  = idx_q;
      if (idx_q == LAST_IDX) begin
        state_d     = IDLE;
        idx_d       = '0;
        step_done_d = 1'b1;
      end else begin
        idx_d = idx_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      spike_valid_q <= 1'b0;
      spike_addr_q  <= '0;
      step_done_q   <= 1'b0;
      for (int n = 0; n < NUM_NEURONS; n++) bank_q[n] <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      spike_valid_q <= spike_valid_d;
      spike_addr_q  <= spike_addr_d;
      step_done_q   <= step_done_d;
      for (int n = 0; n < NUM_NEURONS; n++) bank_q[n] <= bank_d[n];
    end
  end

  assign evReady    = (state_q == IDLE);
  assign busy       = (state_q == SWEEP);
  assign vmemToTh   = (state_q == SWEEP) ? leaked : '0;
  assign spikeValid = spike_valid_q;
  assign spikeAddr  = spike_addr_q;
  assign stepDone   = step_done_q;

endmodule

// File: tb/tb_neuron_integrator.sv
// Bench for neuron_integrator: directed scenarios plus random events/sweeps against an
// arithmetic model of the bank, with a simple threshold unit (vth=100, reset to 0).
module tb_neuron_integrator;

  localparam int NN  = 16;
  localparam int VTH = 100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [6:0]        leak;
  logic              evValid;
  logic              evReady;
  logic [4:0]        evAddr;
  logic signed [7:0] evWeight;
  logic              stepStart;
  logic signed [7:0] vmemToTh;
  logic signed [7:0] vmemFromTh;
  logic              spikeFromTh;
  logic              spikeValid;
  logic [4:0]        spikeAddr;
  logic              busy;
  logic              stepDone;

  int model [NN];
  int checks = 0;
  int errors = 0;

  neuron_integrator #(
    .INTEGER_WIDTH(8), .DATA_WIDTH_FRAC(0), .NUM_NEURONS(NN), .ADDR_WIDTH(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .leak(leak),
    .evValid(evValid), .evReady(evReady), .evAddr(evAddr), .evWeight(evWeight),
    .stepStart(stepStart), .vmemToTh(vmemToTh), .vmemFromTh(vmemFromTh),
    .spikeFromTh(spikeFromTh), .spikeValid(spikeValid), .spikeAddr(spikeAddr),
    .busy(busy), .stepDone(stepDone)
  );

  always #5 clk = ~clk;

  // Threshold unit stand-in: fire and reset at or above vth.
  always_comb begin
    spikeFromTh = ($signed(vmemToTh) >= VTH);
    vmemFromTh  = spikeFromTh ? 8'sd0 : vmemToTh;
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x > 127) ? 127 : ((x < -128) ? -128 : x);
  endfunction

  function automatic int leak_fn(input int v, input int l);
    if (v > 0) return (v > l) ? v - l : 0;
    if (v < 0) return (-v > l) ? v + l : 0;
    return 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_ready", evReady, 1);
    check("rst_spike", spikeValid, 0);
    check("rst_spike_addr", spikeAddr, 0);
    check("rst_done", stepDone, 0);
    check("rst_vmem", $signed(vmemToTh), 0);
    #2;
    rst_n = 1'b1;
    for (int n = 0; n < NN; n++) model[n] = 0;
  endtask

  task automatic do_event(input int a, input int w);
    evValid  = 1'b1;
    evAddr   = a[4:0];
    evWeight = w[7:0];
    check("ev_ready", evReady, 1);
    tick;
    evValid = 1'b0;
    if (a < NN) model[a] = sat(model[a] + w);
    check("ev_no_spike", spikeValid, 0);
  endtask

  task automatic run_sweep(input int lk, input bit ev_start, input bit ev_during,
                           input int ea, input int ew);
    int exp_sp;
    int exp_ad;
    int lv;
    exp_sp = 0;
    exp_ad = 0;
    leak      = lk[6:0];
    stepStart = 1'b1;
    evAddr    = ea[4:0];
    evWeight  = ew[7:0];
    evValid   = ev_start;
    if (ev_start && ea < NN) model[ea] = sat(model[ea] + ew);
    tick;
    stepStart = 1'b0;
    evValid   = ev_during;
    for (int i = 0; i < NN; i++) begin
      check("sw_busy", busy, 1);
      check("sw_ready", evReady, 0);
      check("sw_done_early", stepDone, 0);
      check("sw_spike", spikeValid, exp_sp);
      if (exp_sp != 0) check("sw_spike_addr", spikeAddr, exp_ad);
      lv = leak_fn(model[i], lk);
      check("sw_vmem_to_th", $signed(vmemToTh), lv);
      exp_sp   = (lv >= VTH) ? 1 : 0;
      exp_ad   = i;
      model[i] = (exp_sp != 0) ? 0 : lv;
      stepStart = (i >= 3 && i <= 5);
      tick;
    end
    check("done_pulse", stepDone, 1);
    check("done_busy", busy, 0);
    check("done_ready", evReady, 1);
    check("done_spike", spikeValid, exp_sp);
    if (exp_sp != 0) check("done_spike_addr", spikeAddr, exp_ad);
    check("done_vmem_idle", $signed(vmemToTh), 0);
    if (ev_during && ea < NN) model[ea] = sat(model[ea] + ew);
    tick;
    evValid = 1'b0;
    check("post_done", stepDone, 0);
    check("post_spike", spikeValid, 0);
    check("post_busy", busy, 0);
  endtask

  initial begin
    int ne, lk, ea, ew;
    rst_n = 1'b0; leak = '0; evValid = 1'b0; evAddr = '0; evWeight = '0; stepStart = 1'b0;
    #12;
    tick;
    do_reset;

    // Accumulate to 80, then push past threshold at neuron 3.
    repeat (4) do_event(3, 20);
    run_sweep(0, 0, 0, 0, 0);
    do_event(3, 30);
    run_sweep(0, 0, 0, 0, 0);
    run_sweep(0, 0, 0, 0, 0);

    // Saturation both ways.
    do_reset;
    do_event(5, 120); do_event(5, 50);
    do_event(6, -120); do_event(6, -50);
    do_event(7, -128); do_event(7, -128);
    run_sweep(0, 0, 0, 0, 0);

    // Leak toward zero without crossing.
    do_reset;
    do_event(1, 7); do_event(2, -25); do_event(4, 60); do_event(8, -9);
    run_sweep(10, 0, 0, 0, 0);

    // Event with stepStart in the same cycle, and events held off during the sweep.
    do_reset;
    run_sweep(0, 1, 1, 0, 5);
    run_sweep(0, 0, 0, 0, 0);

    // Out-of-range address is accepted but changes nothing.
    do_event(17, 50);
    do_event(16, 90);
    run_sweep(0, 1, 1, 17, 99);

    // Reset in the middle of a sweep.
    do_event(9, 40);
    leak = '0; stepStart = 1'b1;
    tick;
    stepStart = 1'b0;
    repeat (7) tick;
    check("mid_busy_before_rst", busy, 1);
    do_reset;
    for (int c = 0; c < 20; c++) begin
      check("after_rst_done", stepDone, 0);
      check("after_rst_busy", busy, 0);
      tick;
    end
    run_sweep(0, 0, 0, 0, 0);

    // Random traffic.
    for (int it = 0; it < 40; it++) begin
      ne = $urandom_range(0, 6);
      for (int e = 0; e < ne; e++) begin
        ea = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 15);
        ew = int'($urandom_range(0, 200)) - 80;
        do_event(ea, ew);
      end
      lk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 15);
      ea = $urandom_range(0, 17);
      ew = int'($urandom_range(0, 255)) - 128;
      run_sweep(lk, $urandom_range(0, 1), $urandom_range(0, 1), ea, ew);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_integrator.md
Name: neuron_integrator

Overview:
- Membrane-potential store and integration stage that sits directly upstream of the threshold unit.
- Holds vmem for NUM_NEURONS time-multiplexed neurons and accumulates weighted input events with saturation.
- On each timestep it runs a leak sweep. Every leaked vmem goes to the combinational threshold unit, and the returned value (reset or retained) is written back.
- Spikes produced by the threshold unit are forwarded, registered, to the downstream spike logic.

Parameters:
- INTEGER_WIDTH, 8, integer bits of vmem/weight
- DATA_WIDTH_FRAC, 0, fractional bits
- DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC, total signed width
- NUM_NEURONS, 16, neurons held in the bank (>=2)
- ADDR_WIDTH, 4, neuron index width; must satisfy 2^ADDR_WIDTH >= NUM_NEURONS

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- leak  in  DATA_WIDTH-1  unsigned leak magnitude per timestep
- evValid  in  1  input event valid
- evReady  out  1  event accepted when evValid&&evReady
- evAddr  in  ADDR_WIDTH  target neuron
- evWeight  in  DATA_WIDTH  signed synaptic weight
- stepStart  in  1  timestep pulse; starts leak/threshold sweep
- vmemToTh  out  DATA_WIDTH  signed leaked vmem to threshold unit (combinational from bank)
- vmemFromTh  in  DATA_WIDTH  signed post-threshold vmem returned from threshold unit
- spikeFromTh  in  1  spike flag returned from threshold unit
- spikeValid  out  1  registered spike strobe
- spikeAddr  out  ADDR_WIDTH  neuron index of the spike
- busy  out  1  high while in SWEEP
- stepDone  out  1  one-cycle pulse after the last neuron is swept

Behaviour:
- Reset (rst_n=0, async):
  - all bank entries = 0, state = IDLE, sweep index = 0.
  - spikeValid, spikeAddr, stepDone = 0.
  - Effect is immediate, including mid-sweep; any partial sweep is abandoned.
- States: IDLE, SWEEP.
- IDLE:
  - evReady=1, busy=0.
  - Accepted event: at the next edge, bank[evAddr] <= sat(bank[evAddr] + evWeight). One event per cycle. Back-to-back events to the same address accumulate correctly (read-modify-write completes within one cycle).
  - evAddr >= NUM_NEURONS: event accepted and dropped; no bank change.
  - stepStart=1: transition to SWEEP, index=0.
  - stepStart and an accepted event in the same cycle: the event write lands at that edge, before the sweep reads neuron 0.
- SWEEP:
  - evReady=0, busy=1. stepStart is ignored.
  - One neuron per cycle, index i = 0..NUM_NEURONS-1.
  - vmemToTh = leakToward0(bank[i]):
    - v>0: max(v-leak, 0)
    - v<0: min(v+leak, 0)
    - v=0: 0
  - At each edge: bank[i] <= vmemFromTh; spikeValid <= spikeFromTh; spikeAddr <= i.
  - After i = NUM_NEURONS-1: stepDone=1 for exactly one cycle (coincident with the last spikeValid), state returns to IDLE.
  - Sweep latency: NUM_NEURONS cycles from the stepStart edge. Next events are accepted in the cycle stepDone is high.
- IDLE outputs:
  - vmemToTh = 0.
  - spikeValid and stepDone deassert the cycle after the sweep ends.
- Arithmetic:
  - Sum computed at DATA_WIDTH+1 bits.
  - sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Leak never crosses zero and never overflows.
- spikeValid is asserted only during SWEEP-generated cycles; it is never asserted from events.

Test Plan:
- Reset then 4 events to neuron 3, weight +20 each; then stepStart with leak=0 and threshold vth=100 -> no spike, bank[3]=80. Next step, event +30 then stepStart -> spikeValid with spikeAddr=3 in sweep cycle 4, bank[3]=0 afterwards.
- Saturation: bank[5]=120, event +50 -> bank[5]=127. bank[6]=-120, event -50 -> bank[6]=-128.
- Leak: leak=10, bank[1]=7 -> 0; bank[2]=-25 -> -15; bank[0]=0 -> 0. stepDone exactly NUM_NEURONS (16) cycles after the stepStart edge; busy high for those 16 cycles.
- stepStart and event (neuron 0, +5) in the same IDLE cycle -> event applied, vmemToTh at sweep cycle 0 = 5 (leak=0). Events offered during SWEEP see evReady=0 and are accepted after stepDone.
- rst_n pulsed low at sweep index 7 -> immediate IDLE, busy=0, all vmem=0, no stepDone. A subsequent stepStart produces a full 16-cycle sweep.
- Out-of-range evAddr=17 with ADDR_WIDTH=5 and NUM_NEURONS=16 -> accepted, no bank change, no spike.
